cpu_cen_ctrl: RTL and testbench

Parametrised CPU clock-enable controller sitting between the fractional clock generators and the main CPU core in the M90-family top levels. It derives a base CPU tick from `clk_sys` by fractional division and gates it with any number of stall sources (ROM cache, video chip busy, future DMA). It tracks ticks lost to stalls as a saturating debt and repays them once the stall clears. It also owns the vsync-aligned pause handshake and the turbo override, replacing the ad-hoc counter and pause logic in each board top.

---
 rtl/cen_pkg.sv | 17 +
 rtl/frac_tick.sv | 33 +++
 rtl/cpu_cen_ctrl.sv | 127 ++++++++++++
 tb/tb_cpu_cen_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cen_pkg.sv
// Shared types and helpers for the clock-enable controllers.
package cen_pkg;

  // Pause handshake states.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    PAUSED = 2'd2,
    RESUME = 2'd3
  } pause_state_t;

  // Largest value representable in a debt counter of width w.
  function automatic int unsigned debt_max_of(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/frac_tick.sv
// Fractional tick generator: asserts tick on NUM out of every DEN cycles,
// spread as evenly as the accumulator allows.
module frac_tick #(
  parameter int NUM   = 2,
  parameter int DEN   = 5,
  parameter int ACC_W = 10
) (
  input  logic clk_sys,
  input  logic reset_n,
  output logic tick
);

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W:0]   w_sum;
  logic             w_wrap;

  // One extra bit so the compare never sees a wrapped sum.
  assign w_sum  = {1'b0, r_acc} + (ACC_W+1)'(NUM);
  assign w_wrap = (w_sum >= (ACC_W+1)'(DEN));
  assign tick   = reset_n & w_wrap;

  // Accumulate NUM each cycle, folding back by DEN on every tick.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (w_wrap) begin
      r_acc <= w_sum[ACC_W-1:0] - ACC_W'(DEN);
    end else begin
      r_acc <= w_sum[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/cpu_cen_ctrl.sv
// CPU clock-enable controller: fractional base tick, stall gating with
// saturating debt repayment, vsync-aligned pause handshake and turbo.
module cpu_cen_ctrl
  import cen_pkg::*;
#(
  parameter int          NUM      = 2,
  parameter int          DEN      = 5,
  parameter int          ACC_W    = 10,
  parameter int          N_STALL  = 2,
  parameter int          DEBT_W   = 16,
  parameter int unsigned DEBT_MAX = debt_max_of(DEBT_W)
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [N_STALL-1:0] stall,
  input  logic               turbo,
  input  logic               pause_rq,
  input  logic               vsync,
  output logic               ce_cpu,
  output logic               ce_half,
  output logic               paused,
  output logic [DEBT_W-1:0]  debt,
  output logic               debt_ovf
);

  localparam logic [DEBT_W-1:0] L_DEBT_MAX = DEBT_W'(DEBT_MAX);

  logic              w_tick;
  logic              w_stl;
  logic              w_run;
  logic              w_debt_nz;
  logic              w_vs_rise;

  logic [DEBT_W-1:0] r_debt;
  logic              r_debt_ovf;
  logic              r_ph;
  logic              r_ce_half;
  logic              r_vsync_q;
  logic              r_paused;
  pause_state_t      r_state;

  frac_tick #(
    .NUM   (NUM),
    .DEN   (DEN),
    .ACC_W (ACC_W)
  ) u_frac_tick (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .tick    (w_tick)
  );

  assign w_stl     = |stall;
  assign w_run     = ~r_paused & ~w_stl;
  assign w_debt_nz = |r_debt;
  assign w_vs_rise = vsync & ~r_vsync_q;

  // Stall is applied combinationally so a stalled cycle never issues an enable.
  assign ce_cpu = reset_n & w_run & (turbo | w_tick | w_debt_nz);

  assign ce_half  = r_ce_half;
  assign paused   = r_paused;
  assign debt     = r_debt;
  assign debt_ovf = r_debt_ovf;

  // Debt: count ticks lost to stalls, repay them on free non-tick cycles.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_debt     <= '0;
      r_debt_ovf <= 1'b0;
    end else if (turbo) begin
      r_debt <= '0;
    end else if (r_paused) begin
      r_debt <= r_debt;
    end else if (w_tick & w_stl) begin
      if (r_debt == L_DEBT_MAX) begin
        r_debt_ovf <= 1'b1;
      end else begin
        r_debt <= r_debt + 1'b1;
      end
    end else if (~w_tick & ~w_stl & w_debt_nz) begin
      r_debt <= r_debt - 1'b1;
    end
  end

  // Half-rate enable: every second base tick, regardless of stall or pause.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_ph      <= 1'b0;
      r_ce_half <= 1'b0;
    end else begin
      r_ce_half <= w_tick & r_ph;
      if (w_tick) begin
        r_ph <= ~r_ph;
      end
    end
  end

  // Pause handshake: enter on a vsync rising edge, leave once vsync is low.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state   <= RUN;
      r_vsync_q <= 1'b0;
      r_paused  <= 1'b0;
    end else begin
      r_vsync_q <= vsync;
      r_paused  <= (r_state == PAUSED) || (r_state == RESUME);
      unique case (r_state)
        RUN: begin
          if (pause_rq) r_state <= PEND;
        end
        PEND: begin
          if (!pause_rq)                 r_state <= RUN;
          else if (w_vs_rise)            r_state <= PAUSED;
        end
        PAUSED: begin
          if (!pause_rq) r_state <= RESUME;
        end
        RESUME: begin
          if (pause_rq)                  r_state <= PAUSED;
          else if (!vsync)               r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_cen_ctrl.sv
// Self-checking bench for cpu_cen_ctrl: default instance plus a 3-bit debt
// instance driven by the same stimulus, compared against a cycle model.
module tb_cpu_cen_ctrl;

  localparam int NUM = 2;
  localparam int DEN = 5;

  localparam int S_RUN    = 0;
  localparam int S_PEND   = 1;
  localparam int S_PAUSED = 2;
  localparam int S_RESUME = 3;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [1:0]  stall;
  logic        turbo;
  logic        pause_rq;
  logic        vsync;

  logic        ce_cpu0, ce_half0, paused0, ovf0;
  logic [15:0] debt0;
  logic        ce_cpu1, ce_half1, paused1, ovf1;
  logic [2:0]  debt1;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  int m_n;
  int m_state;
  int m_paused;
  int m_vsq;
  int m_half;
  int m_debt [2];
  int m_ovf  [2];
  int dmax   [2] = '{65535, 7};

  // values sampled on the last step
  int last_ce0, last_half0, last_paused0, last_debt0, last_debt1, last_ovf1;

  always #5 clk_sys = ~clk_sys;

  cpu_cen_ctrl #(.NUM(NUM), .DEN(DEN), .ACC_W(10), .N_STALL(2), .DEBT_W(16)) u_dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .stall    (stall),
    .turbo    (turbo),
    .pause_rq (pause_rq),
    .vsync    (vsync),
    .ce_cpu   (ce_cpu0),
    .ce_half  (ce_half0),
    .paused   (paused0),
    .debt     (debt0),
    .debt_ovf (ovf0)
  );

  cpu_cen_ctrl #(.NUM(NUM), .DEN(DEN), .ACC_W(10), .N_STALL(2), .DEBT_W(3)) u_dut3 (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .stall    (stall),
    .turbo    (turbo),
    .pause_rq (pause_rq),
    .vsync    (vsync),
    .ce_cpu   (ce_cpu1),
    .ce_half  (ce_half1),
    .paused   (paused1),
    .debt     (debt1),
    .debt_ovf (ovf1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Base tick n cycles after reset release: the integer part of n*NUM/DEN steps.
  function automatic int tick_at(input int n);
    return (((n + 1) * NUM) / DEN) != ((n * NUM) / DEN) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_n = 0; m_state = S_RUN; m_paused = 0; m_vsq = 0; m_half = 0;
    for (int k = 0; k < 2; k++) begin
      m_debt[k] = 0;
      m_ovf[k]  = 0;
    end
  endtask

  task automatic compare();
    int tk, stl, exp_ce;
    tk  = reset_n ? tick_at(m_n) : 0;
    stl = (stall != 2'b00) ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      exp_ce = (reset_n && !m_paused && !stl && (turbo || tk || m_debt[k] != 0)) ? 1 : 0;
      if (k == 0) begin
        chk("ce_cpu",   int'(ce_cpu0),  exp_ce);
        chk("ce_half",  int'(ce_half0), m_half);
        chk("paused",   int'(paused0),  m_paused);
        chk("debt",     int'(debt0),    m_debt[0]);
        chk("debt_ovf", int'(ovf0),     m_ovf[0]);
      end else begin
        chk("ce_cpu_w3",   int'(ce_cpu1),  exp_ce);
        chk("ce_half_w3",  int'(ce_half1), m_half);
        chk("paused_w3",   int'(paused1),  m_paused);
        chk("debt_w3",     int'(debt1),    m_debt[1]);
        chk("debt_ovf_w3", int'(ovf1),     m_ovf[1]);
      end
    end
    last_ce0     = int'(ce_cpu0);
    last_half0   = int'(ce_half0);
    last_paused0 = int'(paused0);
    last_debt0   = int'(debt0);
    last_debt1   = int'(debt1);
    last_ovf1    = int'(ovf1);
  endtask

  task automatic model_update();
    int tk, stl, vs_rise, nxt;
    if (!reset_n) begin
      model_reset();
      return;
    end
    tk  = tick_at(m_n);
    stl = (stall != 2'b00) ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      if (turbo) m_debt[k] = 0;
      else if (m_paused) m_debt[k] = m_debt[k];
      else if (tk && stl) begin
        if (m_debt[k] == dmax[k]) m_ovf[k] = 1;
        else m_debt[k] = m_debt[k] + 1;
      end else if (!tk && !stl && m_debt[k] > 0) m_debt[k] = m_debt[k] - 1;
    end
    m_half   = (tk && (((m_n * NUM) / DEN) % 2 == 1)) ? 1 : 0;
    m_paused = (m_state == S_PAUSED || m_state == S_RESUME) ? 1 : 0;
    vs_rise  = (vsync && !m_vsq) ? 1 : 0;
    nxt = m_state;
    if (m_state == S_RUN && pause_rq) nxt = S_PEND;
    if (m_state == S_PEND) nxt = !pause_rq ? S_RUN : (vs_rise ? S_PAUSED : S_PEND);
    if (m_state == S_PAUSED && !pause_rq) nxt = S_RESUME;
    if (m_state == S_RESUME) nxt = pause_rq ? S_PAUSED : (!vsync ? S_RUN : S_RESUME);
    m_state = nxt;
    m_vsq = vsync ? 1 : 0;
    m_n++;
  endtask

  task automatic step();
    @(negedge clk_sys);
    compare();
    model_update();
    @(posedge clk_sys);
    #1;
  endtask

  initial begin
    int cnt_ce, cnt_half, first_ce;
    reset_n = 1'b0; stall = 2'b00; turbo = 1'b0; pause_rq = 1'b0; vsync = 1'b0;
    model_reset();
    @(posedge clk_sys);
    #1;
    repeat (3) step();
    $display("phase reset: held 3 cycles");

    // defaults, free running
    reset_n = 1'b1;
    cnt_ce = 0; cnt_half = 0; first_ce = -1;
    for (int i = 0; i <= 50; i++) begin
      step();
      if (i < 50 && last_ce0 != 0) begin
        cnt_ce++;
        if (first_ce < 0) first_ce = i;
      end
      if (i >= 1 && last_half0 != 0) cnt_half++;
    end
    chk("p1_ce_count", cnt_ce, 20);
    chk("p1_half_count", cnt_half, 10);
    chk("p1_first_ce", first_ce, 2);
    $display("phase free-run: ce=%0d half=%0d first=%0d", cnt_ce, cnt_half, first_ce);

    // stall[1] for 25 cycles, then repay
    cnt_ce = 0;
    stall = 2'b10;
    repeat (25) begin
      step();
      cnt_ce += last_ce0;
    end
    stall = 2'b00;
    step();
    cnt_ce += last_ce0;
    chk("p2_debt", last_debt0, 10);
    chk("p2_debt_w3_sat", last_debt1, 7);
    chk("p2_ovf_w3", last_ovf1, 1);
    repeat (74) begin
      step();
      cnt_ce += last_ce0;
    end
    chk("p2_total_ce", cnt_ce, 40);
    chk("p2_debt_drained", last_debt0, 0);
    chk("p2_ovf_w3_sticky", last_ovf1, 1);
    $display("phase stall-repay: ce=%0d", cnt_ce);

    // pause handshake aligned to vsync
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    cnt_ce = 0;
    for (int i = 0; i < 140; i++) begin
      pause_rq = (i >= 10 && i < 120);
      vsync    = (i >= 100 && i < 130);
      stall    = (i >= 105 && i < 115) ? 2'b01 : 2'b00;
      step();
      if (i == 101) chk("p3_paused_101", last_paused0, 0);
      if (i == 102) chk("p3_paused_102", last_paused0, 1);
      if (i == 118) chk("p3_debt_frozen", last_debt0, 0);
      if (i == 131) chk("p3_paused_131", last_paused0, 1);
      if (i == 132) chk("p3_paused_132", last_paused0, 0);
      if (i >= 102 && i <= 131) cnt_ce += last_ce0;
    end
    chk("p3_ce_while_paused", cnt_ce, 0);
    $display("phase pause: ce while paused=%0d", cnt_ce);

    // turbo clears a debt of 5
    stall = 2'b01;
    for (int g = 0; g < 40 && m_debt[0] < 5; g++) step();
    stall = 2'b00;
    turbo = 1'b1;
    step();
    chk("p4_debt_pre", last_debt0, 5);
    step();
    chk("p4_debt_cleared", last_debt0, 0);
    cnt_ce = 0;
    repeat (8) begin
      step();
      cnt_ce += last_ce0;
    end
    chk("p4_turbo_ce", cnt_ce, 8);
    stall = 2'b01;
    step();
    chk("p4_turbo_stall_ce", last_ce0, 0);
    stall = 2'b00;
    turbo = 1'b0;
    step();
    $display("phase turbo: ce=%0d", cnt_ce);

    // reset while in RESUME holding debt
    pause_rq = 1'b1;
    stall = 2'b01;
    repeat (6) step();
    vsync = 1'b1;
    repeat (2) step();
    stall = 2'b00;
    pause_rq = 1'b0;
    repeat (3) step();
    chk("p5_paused_before", last_paused0, 1);
    chk("p5_debt_nonzero", (last_debt0 != 0) ? 1 : 0, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    vsync = 1'b0;
    first_ce = -1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) begin
        chk("p5_paused_after", last_paused0, 0);
        chk("p5_debt_after", last_debt0, 0);
      end
      if (last_ce0 != 0 && first_ce < 0) first_ce = i;
    end
    chk("p5_first_ce", first_ce, 2);
    $display("phase reset-in-resume: first ce=%0d", first_ce);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      stall[0] = ($urandom_range(0, 5) == 0);
      stall[1] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 29) == 0) turbo = ~turbo;
      if ($urandom_range(0, 39) == 0) pause_rq = ~pause_rq;
      vsync   = ((i % 45) >= 40);
      reset_n = ($urandom_range(0, 199) != 0);
      step();
    end
    $display("phase random: 600 cycles");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
